// File: rtl/glb_capture_pkg.sv
// glb_capture_pkg: capture FSM state type and the address-width helper shared by the block capture slice.
package glb_capture_pkg;
  typedef enum logic [1:0] {SIZE, DATA, GAP, DONE} state_t;
  function automatic int addr_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/glb_capture_mem.sv
// glb_capture_mem: block buffer storage, one write port and one registered read port (read-before-write).
module glb_capture_mem
  import glb_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int WORDS = 2048
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [addr_w(WORDS)-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic [addr_w(WORDS)-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]       rdata
);
  logic [DATA_WIDTH-1:0] mem [WORDS];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/glb_block_capture.sv
// glb_block_capture: captures NUM_BLOCKS length-prefixed blocks from a valid/ready stream into per-block buffers.
// Define GLB_CAPTURE_OVERFLOW_CHECK_EN to flag oversize blocks and drop words beyond DEPTH instead of wrapping.
module glb_block_capture
  import glb_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 1024,
  parameter int NUM_BLOCKS = 2,
  localparam int BW = addr_w(NUM_BLOCKS),
  localparam int AW = addr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  input  logic                  restart,
  input  logic [BW-1:0]         rd_blk,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] blk_size,
  output logic                  overflow
);
  localparam int MAW = addr_w(NUM_BLOCKS * DEPTH);
  localparam logic [BW-1:0] LAST = BW'(NUM_BLOCKS - 1);
  state_t state_q, state_d;
  logic [BW-1:0] blk_q;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_inc, mem_rdata;
  logic [DATA_WIDTH-1:0] size_q [NUM_BLOCKS];
  logic xfer, we, rd_ok, rd_ok_q;
  assign ready = !reset && (state_q == SIZE || state_q == DATA);
  assign done = !reset && state_q == DONE;
  assign xfer = valid && ready;
  assign cnt_inc = cnt_q + 1'b1;
  assign rd_ok = 32'(rd_blk) < NUM_BLOCKS;
  assign blk_size = rd_ok ? size_q[rd_blk] : '0;
  assign rd_data = rd_ok_q ? mem_rdata : '0;
`ifdef GLB_CAPTURE_OVERFLOW_CHECK_EN
  logic ovf_q;
  assign overflow = ovf_q;
  assign we = state_q == DATA && xfer && 32'(cnt_q) < DEPTH;
`else
  assign overflow = 1'b0;
  assign we = state_q == DATA && xfer;
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      SIZE: if (xfer) state_d = (data == '0) ? GAP : DATA;
      DATA: if (xfer && cnt_inc == size_q[blk_q]) state_d = GAP;
      GAP:  state_d = (blk_q == LAST) ? DONE : SIZE;
      DONE: if (restart) state_d = SIZE;
      default: state_d = SIZE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SIZE;
      blk_q <= '0;
      cnt_q <= '0;
      rd_ok_q <= 1'b0;
      for (int i = 0; i < NUM_BLOCKS; i++) size_q[i] <= '0;
`ifdef GLB_CAPTURE_OVERFLOW_CHECK_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rd_ok_q <= rd_ok;
      if (state_q == SIZE && xfer) begin
        size_q[blk_q] <= data;
        cnt_q <= '0;
`ifdef GLB_CAPTURE_OVERFLOW_CHECK_EN
        if (32'(data) > DEPTH) ovf_q <= 1'b1;
`endif
      end
      if (state_q == DATA && xfer) cnt_q <= cnt_inc;
      if (state_q == GAP && blk_q != LAST) blk_q <= BW'(blk_q + 1'b1);
      if (state_q == DONE && restart) begin
        blk_q <= '0;
`ifdef GLB_CAPTURE_OVERFLOW_CHECK_EN
        ovf_q <= 1'b0;
`endif
      end
    end
  end
  glb_capture_mem #(.DATA_WIDTH(DATA_WIDTH), .WORDS(NUM_BLOCKS * DEPTH)) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(MAW'({blk_q, AW'(cnt_q)})),
    .wdata(data),
    .raddr(rd_ok ? MAW'({rd_blk, rd_addr}) : '0),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_glb_block_capture.sv
// tb_glb_block_capture: directed and randomized block streams checked against a block-level reference model.
module tb_glb_block_capture;
  localparam int DW = 16, DEPTH = 16, NB = 2;
  logic clk = 0, reset = 1, valid = 0, restart = 0;
  logic [DW-1:0] data = '0;
  logic ready, done, overflow;
  logic [0:0] rd_blk = '0;
  logic [3:0] rd_addr = '0;
  logic [DW-1:0] rd_data, blk_size;
  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] exp_mem [NB][DEPTH];
  bit exp_wr [NB][DEPTH];
  logic [DW-1:0] exp_size [NB];
  bit exp_ovf = 0;

  glb_block_capture #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_BLOCKS(NB)) dut (
    .clk(clk), .reset(reset), .data(data), .valid(valid), .ready(ready), .done(done),
    .restart(restart), .rd_blk(rd_blk), .rd_addr(rd_addr), .rd_data(rd_data),
    .blk_size(blk_size), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic send(input logic [DW-1:0] w);
    int t = 0;
    data = w;
    valid = 1;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("ready_timeout", 0, 1);
    @(negedge clk);
    valid = 0;
  endtask

  task automatic idle(input int k);
    valid = 0;
    repeat (k) @(negedge clk);
  endtask

  // gapmode: 0 back-to-back, 1 valid every other cycle, 2 random gaps, 3 restart pulse mid-payload
  task automatic send_block(input int b, input int n, input int gapmode, input logic [DW-1:0] base);
    logic [DW-1:0] w;
    int a;
    send(DW'(n));
    exp_size[b] = DW'(n);
`ifdef GLB_CAPTURE_OVERFLOW_CHECK_EN
    if (n > DEPTH) exp_ovf = 1;
`endif
    chk("overflow_after_size", overflow, exp_ovf);
    for (int i = 0; i < n; i++) begin
      w = (base != 0) ? DW'(base + i) : DW'($urandom);
      if (gapmode == 1 && i % 2 == 1) idle(1);
      if (gapmode == 2) idle($urandom_range(0, 2));
      if (gapmode == 3 && i == 2) begin
        restart = 1;
        idle(1);
        restart = 0;
        chk("restart_in_data_done", done, 0);
      end
      a = i % DEPTH;
      rd_blk = 1'(b);
      rd_addr = 4'(a);
      send(w);
      if (exp_wr[b][a]) chk("same_cycle_read_old", rd_data, exp_mem[b][a]);
`ifdef GLB_CAPTURE_OVERFLOW_CHECK_EN
      if (i < DEPTH) begin
`else
      begin
`endif
        exp_mem[b][a] = w;
        exp_wr[b][a] = 1;
      end
    end
    chk("gap_ready_low", ready, 0);
    chk("overflow_block_end", overflow, exp_ovf);
    if (b == NB - 1) begin
      @(negedge clk);
      chk("done_high", done, 1);
      chk("done_ready_low", ready, 0);
    end else chk("done_low_midrun", done, 0);
  endtask

  task automatic readback();
    for (int b = 0; b < NB; b++) begin
      rd_blk = 1'(b);
      #1;
      chk($sformatf("blk_size%0d", b), blk_size, exp_size[b]);
      for (int a = 0; a < DEPTH; a++) begin
        if (!exp_wr[b][a]) continue;
        rd_addr = 4'(a);
        @(negedge clk);
        chk($sformatf("rd_data_b%0d_a%0d", b, a), rd_data, exp_mem[b][a]);
      end
    end
  endtask

  task automatic do_restart();
    chk("restart_from_done", done, 1);
    restart = 1;
    @(negedge clk);
    restart = 0;
    exp_ovf = 0;
    chk("restart_done_low", done, 0);
    chk("restart_ready_high", ready, 1);
    chk("restart_ovf_clear", overflow, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    valid = 1;
    data = DW'(5);
    #1;
    chk("reset_ready_low", ready, 0);
    @(negedge clk);
    valid = 0;
    reset = 0;
    for (int b = 0; b < NB; b++) exp_size[b] = '0;
    exp_ovf = 0;
    #1;
    chk("post_reset_ready", ready, 1);
    chk("post_reset_done", done, 0);
    chk("post_reset_ovf", overflow, 0);
    chk("post_reset_rd_data", rd_data, 0);
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      exp_size[b] = '0;
      for (int a = 0; a < DEPTH; a++) exp_wr[b][a] = 0;
    end
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 0);
    chk("reset_done", done, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_rd_data", rd_data, 0);
    rd_blk = 1'b1;
    #1;
    chk("reset_blk_size", blk_size, 0);
    reset = 0;
    #1;
    chk("ready_after_reset", ready, 1);
    send_block(0, 4, 0, DW'('hA));
    send_block(1, 3, 0, DW'(1));
    readback();
    do_restart();
    send_block(0, 0, 0, '0);
    send_block(1, 2, 0, DW'(7));
    readback();
    do_restart();
    send_block(0, 5, 1, '0);
    send_block(1, 4, 3, '0);
    readback();
    do_restart();
    send(DW'(4));
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] w = DW'($urandom);
      send(w);
      exp_mem[0][i] = w;
      exp_wr[0][i] = 1;
    end
    do_reset();
    send_block(0, 3, 2, '0);
    send_block(1, 1, 0, '0);
    readback();
    do_restart();
    send_block(0, 20, 0, DW'('h100));
    send_block(1, 1, 0, '0);
    readback();
    for (int r = 0; r < 3; r++) begin
      do_restart();
      for (int b = 0; b < NB; b++) send_block(b, $urandom_range(0, 20), $urandom_range(0, 2), '0);
      readback();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/glb_block_capture.md
GLB_BLOCK_CAPTURE -- requirements
Module: glb_block_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 16, SHALL set the stream word and stored word width (8..32).
REQ-002 Parameter DEPTH, default 1024, SHALL set the words per block buffer (power of two, >=2).
REQ-003 Parameter NUM_BLOCKS, default 2, SHALL set the number of length-prefixed blocks captured per run (1..8).
REQ-004 clk  input  1  SHALL be the single clock, rising-edge.
REQ-005 reset  input  1  SHALL be synchronous, active-high reset.
REQ-006 data  input  DATA_WIDTH  SHALL carry stream words: a size word, then payload.
REQ-007 valid  input  1  SHALL qualify data.
REQ-008 ready  output  1  SHALL indicate the block accepts data; a transfer occurs when valid and ready are both high at a clk edge.
REQ-009 done  output  1  SHALL be high once all NUM_BLOCKS blocks are captured.
REQ-010 restart  input  1  SHALL re-arm capture from DONE.
REQ-011 rd_blk  input  clog2(NUM_BLOCKS) (min 1)  SHALL select the readback block.
REQ-012 rd_addr  input  clog2(DEPTH)  SHALL select the readback word.
REQ-013 rd_data  output  DATA_WIDTH  SHALL return the stored word one cycle after rd_blk/rd_addr.
REQ-014 blk_size  output  DATA_WIDTH  SHALL return the captured size word of rd_blk, combinationally.
REQ-015 overflow  output  1  SHALL flag a size word greater than DEPTH (only with REQ-031).

Function
REQ-016 FSM states SHALL be SIZE, DATA, GAP, DONE; reset state SIZE with block index 0.
REQ-017 In SIZE, ready=1; a transfer SHALL latch data into size[blk], clear word count, go to DATA; size 0 SHALL go directly to GAP.
REQ-018 In DATA, ready=1; each transfer SHALL write data to mem[blk][count] and increment count.
REQ-019 When the transfer making count equal size[blk] occurs, FSM SHALL go to GAP on the next edge.
REQ-020 In GAP, ready=0 for exactly one cycle; then SIZE with blk+1, or DONE if blk == NUM_BLOCKS-1.
REQ-021 In DONE, ready=0 and done=1; restart=1 SHALL return to SIZE, blk=0, done=0 next cycle; stored data and sizes SHALL be retained until overwritten.
REQ-022 restart outside DONE SHALL be ignored.
REQ-023 valid with ready=0 SHALL be ignored; no word is lost by the block while ready=1.
REQ-024 Word count SHALL be DATA_WIDTH bits wide; memory address SHALL be count modulo DEPTH.
REQ-025 Readback SHALL be independent of capture; a read of the address written in the same cycle SHALL return the old value.
REQ-026 rd_blk >= NUM_BLOCKS SHALL return rd_data=0 and blk_size=0.

Reset
REQ-027 reset SHALL force: state SIZE, blk 0, count 0, ready 0 in the reset cycle then 1, done 0, overflow 0, all size registers 0, rd_data 0.
REQ-028 reset mid-block SHALL abandon the partial block; memory contents SHALL NOT be cleared.
REQ-029 reset SHALL take priority over restart and any transfer in the same cycle.

Configuration
REQ-030 Macro GLB_CAPTURE_OVERFLOW_CHECK_EN SHALL compile the overflow check in or out.
REQ-031 Defined: size word > DEPTH SHALL set overflow (sticky until reset or restart); payload words with count >= DEPTH SHALL be accepted and discarded (no write); size[blk] keeps the received value.
REQ-032 Undefined: overflow SHALL be tied 0; writes SHALL wrap modulo DEPTH.

Structure
REQ-033 Package glb_capture_pkg SHALL hold the FSM state enum and an address-width helper function.
REQ-034 Storage SHALL be a sub-module glb_capture_mem: one write port, one registered read port, NUM_BLOCKS*DEPTH words addressed by {blk, addr}.
REQ-035 Target implementation size 120-400 lines of RTL total.

Verification
REQ-036 NUM_BLOCKS=2, DEPTH=16: send 4, A,B,C,D then 3, 1,2,3 -> ready low one cycle after D, done after 3; readback blk0 addr0..3 = A..D, blk_size(1)=3.
REQ-037 Size 0 then size 2, 7,8 -> block 0 empty, blk_size(0)=0, block 1 holds 7,8, done=1.
REQ-038 valid toggled every other cycle during payload of 5 -> all 5 words stored in order, no duplicates.
REQ-039 reset asserted after 2 of 4 payload words -> state SIZE, done=0; next stream captured from addr 0 of blk 0.
REQ-040 With macro, DEPTH=16, size 20 -> overflow=1, words 0..15 stored, 16..19 dropped, done after 20 words; without macro -> overflow=0, addr 0..3 hold words 16..19.
REQ-041 restart in DONE -> done=0 next cycle, ready=1, second run overwrites blocks; restart during DATA -> no effect.
